voice_allocator: RTL

Parametrised polyphonic voice allocator for the MIDI synth core.
- Accepts note-on/note-off events, one at a time, from the MIDI FIFO through a valid/ready handshake.
- Keeps a register-based voice table and issues start/release commands per voice to the sample/envelope engine.
- Generalises the fixed 32-slot RAM search: voice count is configurable, plus retrigger, velocity-0 note-off, oldest-voice stealing and statistics.

---
 rtl/voice_allocator.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: accepts note events, scans a register voice table
// one slot per cycle and issues one start/release command. Optional stealing: VOICE_STEAL_EN.
module voice_allocator #(
    parameter int NUM_VOICES = 32,
    parameter int VOICE_BITS = 5,
    parameter int AGE_W      = 8
) (
    input  logic                  clk32,
    input  logic                  rst,
    input  logic                  ev_valid,
    output logic                  ev_ready,
    input  logic                  ev_note_on,
    input  logic [6:0]            ev_note,
    input  logic [3:0]            ev_channel,
    input  logic [6:0]            ev_velocity,
    input  logic [NUM_VOICES-1:0] voice_free,
    output logic                  alloc_valid,
    output logic [VOICE_BITS-1:0] alloc_voice,
    output logic                  alloc_on,
    output logic [6:0]            alloc_note,
    output logic [3:0]            alloc_channel,
    output logic [6:0]            alloc_velocity,
    output logic                  alloc_stolen,
    output logic [VOICE_BITS:0]   active_count,
    output logic [7:0]            drop_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;

    localparam logic [VOICE_BITS-1:0] LAST_IDX = VOICE_BITS'(NUM_VOICES - 1);
    localparam logic [AGE_W-1:0]      AGE_MAX  = {AGE_W{1'b1}};

    logic [1:0]            state_q, state_d;
    logic [VOICE_BITS-1:0] scan_idx_q, scan_idx_d;

    logic                  evt_on_q, evt_on_d;
    logic [6:0]            evt_note_q, evt_note_d;
    logic [3:0]            evt_chan_q, evt_chan_d;
    logic [6:0]            evt_vel_q, evt_vel_d;

    logic                  match_found_q, match_found_d;
    logic [VOICE_BITS-1:0] match_idx_q, match_idx_d;
    logic                  free_found_q, free_found_d;
    logic [VOICE_BITS-1:0] free_idx_q, free_idx_d;

    logic [NUM_VOICES-1:0]            active_q, active_d;
    logic [NUM_VOICES-1:0]            released_q, released_d;
    logic [NUM_VOICES-1:0][6:0]       note_tab_q, note_tab_d;
    logic [NUM_VOICES-1:0][3:0]       chan_tab_q, chan_tab_d;
    logic [NUM_VOICES-1:0][AGE_W-1:0] age_q, age_d;

    logic [VOICE_BITS:0]   active_count_q, pop_d;
    logic [7:0]            drop_count_q;

    logic                  cmd_valid;
    logic [VOICE_BITS-1:0] cmd_voice;
    logic                  cmd_on;
    logic                  cmd_stolen;
    logic                  cmd_drop;

    logic                  accept;
    logic                  slot_match;

    assign ev_ready   = (state_q == ST_IDLE);
    assign accept     = ev_valid && ev_ready;
    assign slot_match = active_q[scan_idx_q] &&
                        (note_tab_q[scan_idx_q] == evt_note_q) &&
                        (chan_tab_q[scan_idx_q] == evt_chan_q);

`ifdef VOICE_STEAL_EN
    logic                  old_found_q;
    logic [VOICE_BITS-1:0] old_idx_q;
    logic [AGE_W-1:0]      old_age_q;

    // Strictly-greater compare keeps the lowest index among equally old voices.
    always_ff @(posedge clk32) begin
        if (rst || accept) begin
            old_found_q <= 1'b0;
            old_idx_q   <= '0;
            old_age_q   <= '0;
        end else if (state_q == ST_SCAN && active_q[scan_idx_q] &&
                     (!old_found_q || age_q[scan_idx_q] > old_age_q)) begin
            old_found_q <= 1'b1;
            old_idx_q   <= scan_idx_q;
            old_age_q   <= age_q[scan_idx_q];
        end
    end
`endif

    always_comb begin
        state_d       = state_q;
        scan_idx_d    = scan_idx_q;
        evt_on_d      = evt_on_q;
        evt_note_d    = evt_note_q;
        evt_chan_d    = evt_chan_q;
        evt_vel_d     = evt_vel_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    // Velocity-0 note-on is a note-off from here on.
                    evt_on_d      = ev_note_on && (ev_velocity != 7'd0);
                    evt_note_d    = ev_note;
                    evt_chan_d    = ev_channel;
                    evt_vel_d     = ev_velocity;
                    match_found_d = 1'b0;
                    match_idx_d   = '0;
                    free_found_d  = 1'b0;
                    free_idx_d    = '0;
                    scan_idx_d    = '0;
                    state_d       = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!match_found_q && slot_match) begin
                    match_found_d = 1'b1;
                    match_idx_d   = scan_idx_q;
                end
                if (!free_found_q && !active_q[scan_idx_q]) begin
                    free_found_d = 1'b1;
                    free_idx_d   = scan_idx_q;
                end
                if (scan_idx_q == LAST_IDX) begin
                    state_d = ST_ISSUE;
                end else begin
                    scan_idx_d = scan_idx_q + VOICE_BITS'(1);
                end
            end
            ST_ISSUE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_valid  = 1'b0;
        cmd_voice  = '0;
        cmd_on     = 1'b0;
        cmd_stolen = 1'b0;
        cmd_drop   = 1'b0;
        if (state_q == ST_ISSUE) begin
            if (evt_on_q) begin
                if (match_found_q) begin
                    cmd_valid = 1'b1;
                    cmd_voice = match_idx_q;
                    cmd_on    = 1'b1;
                end else if (free_found_q) begin
                    cmd_valid = 1'b1;
                    cmd_voice = free_idx_q;
                    cmd_on    = 1'b1;
                end else begin
`ifdef VOICE_STEAL_EN
                    if (old_found_q) begin
                        cmd_valid  = 1'b1;
                        cmd_voice  = old_idx_q;
                        cmd_on     = 1'b1;
                        cmd_stolen = 1'b1;
                    end else begin
                        cmd_drop = 1'b1;
                    end
`else
                    cmd_drop = 1'b1;
`endif
                end
            end else begin
                // Release only a voice that is still sounding and not already released.
                if (match_found_q && active_q[match_idx_q] && !released_q[match_idx_q]) begin
                    cmd_valid = 1'b1;
                    cmd_voice = match_idx_q;
                end else begin
                    cmd_drop = 1'b1;
                end
            end
        end
    end

    // Envelope frees apply first so that a same-cycle command write overrides them.
    always_comb begin
        active_d   = active_q;
        released_d = released_q;
        note_tab_d = note_tab_q;
        chan_tab_d = chan_tab_q;
        age_d      = age_q;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (voice_free[i]) begin
                active_d[i]   = 1'b0;
                released_d[i] = 1'b0;
            end
        end
        if (cmd_valid) begin
            if (cmd_on) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (active_q[i] && age_q[i] != AGE_MAX) begin
                        age_d[i] = age_q[i] + AGE_W'(1);
                    end
                end
                active_d[cmd_voice]   = 1'b1;
                released_d[cmd_voice] = 1'b0;
                note_tab_d[cmd_voice] = evt_note_q;
                chan_tab_d[cmd_voice] = evt_chan_q;
                age_d[cmd_voice]      = '0;
            end else begin
                released_d[cmd_voice] = 1'b1;
            end
        end
    end

    always_comb begin
        pop_d = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            pop_d = pop_d + (VOICE_BITS+1)'(active_q[i]);
        end
    end

    always_ff @(posedge clk32) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            scan_idx_q     <= '0;
            evt_on_q       <= 1'b0;
            evt_note_q     <= '0;
            evt_chan_q     <= '0;
            evt_vel_q      <= '0;
            match_found_q  <= 1'b0;
            match_idx_q    <= '0;
            free_found_q   <= 1'b0;
            free_idx_q     <= '0;
            active_q       <= '0;
            released_q     <= '0;
            note_tab_q     <= '0;
            chan_tab_q     <= '0;
            age_q          <= '0;
            active_count_q <= '0;
            drop_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            scan_idx_q     <= scan_idx_d;
            evt_on_q       <= evt_on_d;
            evt_note_q     <= evt_note_d;
            evt_chan_q     <= evt_chan_d;
            evt_vel_q      <= evt_vel_d;
            match_found_q  <= match_found_d;
            match_idx_q    <= match_idx_d;
            free_found_q   <= free_found_d;
            free_idx_q     <= free_idx_d;
            active_q       <= active_d;
            released_q     <= released_d;
            note_tab_q     <= note_tab_d;
            chan_tab_q     <= chan_tab_d;
            age_q          <= age_d;
            active_count_q <= pop_d;
            if (cmd_drop && drop_count_q != 8'hFF) begin
                drop_count_q <= drop_count_q + 8'd1;
            end
        end
    end

    assign alloc_valid    = cmd_valid;
    assign alloc_voice    = cmd_voice;
    assign alloc_on       = cmd_on;
    assign alloc_stolen   = cmd_stolen;
    assign alloc_note     = cmd_valid ? evt_note_q : 7'd0;
    assign alloc_channel  = cmd_valid ? evt_chan_q : 4'd0;
    assign alloc_velocity = cmd_valid ? evt_vel_q  : 7'd0;
    assign active_count   = active_count_q;
    assign drop_count     = drop_count_q;

endmodule
